pipeline_stall_ctrl: RTL
========================

// Module: pipeline_stall_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage MIPS pipeline (PC, IF/ID, ID/EXE, EXE/MEM, MEM/WB).
//  Merges stall requests from instruction fetch, decode (load-use) and the MEM-stage IO unit.
//  Drives one stall vector plus an IF/ID flush for taken branches.
//  Owns the IO handshake: an IO access holds the pipe until the user presses enter.
// PARAMETERS
//  IO_TIMEOUT   0   cycles in IO_WAIT before auto-ack; 0 = wait forever
//  TO_W         24  width of IO wait counter (must hold IO_TIMEOUT)
// PORTS
//  clk           in   1   CPU clock
//  rst           in   1   synchronous, active-high reset
//  stall_req_if  in   1   fetch not ready (level)
//  stall_req_id  in   1   load-use hazard in ID (level)
//  stall_req_io  in   1   MEM-stage IO access needs user input (level, held until insn leaves MEM)
//  enter         in   1   debounced one-cycle pulse from enter button
//  branch_flag   in   1   ID resolved taken branch/jump this cycle
//  stall         out  6   [0]PC [1]IF [2]ID [3]EXE [4]MEM [5]WB; 1 = hold that stage
//  flush         out  1   clear IF/ID to nop next edge
//  io_waiting    out  1   high while waiting for enter (drives LED blink)
//  io_ack        out  1   one-cycle pulse: IO unit samples switches now
// BEHAVIOUR
//  - Reset: stall=6'b000000, flush=0, io_waiting=0, io_ack=0, FSM=RUN, counter=0.
//  - All outputs registered-state driven: stall/flush combinational from FSM + requests, no extra latency.
//  - FSM states: RUN, IO_WAIT, IO_ACK, IO_REL.
//    RUN: stall_req_io=1 -> IO_WAIT (stall=6'b011111 same cycle).
//    IO_WAIT: stall=6'b011111, io_waiting=1, counter++ ; enter=1 or (IO_TIMEOUT!=0 && counter==IO_TIMEOUT-1) -> IO_ACK.
//    IO_ACK: stall=6'b011111, io_ack=1, io_waiting=0 ; -> IO_REL unconditionally.
//    IO_REL: stall_req_io ignored for this one cycle so the insn advances; -> RUN, counter=0.
//  - Priority in RUN/IO_REL (highest first): io 6'b011111 > id 6'b000111 > if 6'b000011 > none 6'b000000.
//  - In IO_REL, id/if requests still apply by the same priority.
//  - flush = branch_flag && !stall[1]; forced 0 whenever stall[1]=1 (branch held with ID).
//  - enter outside IO_WAIT ignored; enter in IO_ACK/IO_REL ignored (no double ack).
//  - enter and timeout in same cycle: single IO_ACK.
//  - Counter saturates at all-ones when IO_TIMEOUT=0; cleared on leaving IO_REL and on rst.
//  - rst mid-IO_WAIT/IO_ACK: immediate return to RUN, no io_ack emitted.
// CONFIGURATION
//  - STALL_PERF_EN defined: adds outputs perf_stall_cycles[31:0], perf_io_waits[15:0];
//    perf_stall_cycles +1 every cycle stall[0]=1; perf_io_waits +1 on each IO_ACK entry;
//    both wrap, both cleared by rst.
//  - STALL_PERF_EN undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  - rst=1 two cycles, all reqs 0 -> stall=0, flush=0, io_waiting=0, io_ack=0.
//  - stall_req_id=1 & stall_req_if=1 -> stall=6'b000111; drop id -> 6'b000011; drop both -> 0.
//  - stall_req_io=1 held, enter pulse at cycle 10 -> stall=6'b011111 cycles 0-11, io_ack=1 at cycle 11, stall=0 cycle 12, RUN cycle 13.
//  - IO_TIMEOUT=5, no enter -> io_ack on 6th cycle after entering IO_WAIT; enter at IO_ACK ignored.
//  - branch_flag=1 with stall=0 -> flush=1; branch_flag=1 with stall_req_id=1 -> flush=0.
//  - rst asserted in IO_WAIT -> next cycle RUN, io_ack never pulses; with STALL_PERF_EN counters read 0.

Source files
------------

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline; owns the IO enter-key handshake.
// Optional performance counters are enabled by defining STALL_PERF_EN.
module pipeline_stall_ctrl #(
  parameter int unsigned IO_TIMEOUT = 0,
  parameter int unsigned TO_W       = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_req_if,
  input  logic        stall_req_id,
  input  logic        stall_req_io,
  input  logic        enter,
  input  logic        branch_flag,
  output logic [5:0]  stall,
  output logic        flush,
  output logic        io_waiting,
  output logic        io_ack
`ifdef STALL_PERF_EN
  ,
  output logic [31:0] perf_stall_cycles,
  output logic [15:0] perf_io_waits
`endif
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_IO_WAIT,
    ST_IO_ACK,
    ST_IO_REL
  } state_t;

  localparam logic [5:0] STALL_IO   = 6'b011111;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(IO_TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            timeout_hit;

  assign timeout_hit = (IO_TIMEOUT != 0) && (cnt_q == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (stall_req_io) state_d = ST_IO_WAIT;
      end
      ST_IO_WAIT: begin
        if (cnt_q != '1) cnt_d = cnt_q + TO_W'(1);
        if (enter || timeout_hit) state_d = ST_IO_ACK;
      end
      ST_IO_ACK: state_d = ST_IO_REL;
      ST_IO_REL: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // IO_REL deliberately ignores stall_req_io so the IO instruction can leave MEM.
  always_comb begin
    logic io_hold;
    io_hold = (state_q == ST_IO_WAIT) || (state_q == ST_IO_ACK) ||
              ((state_q == ST_RUN) && stall_req_io);
    stall = '0;
    if (io_hold)           stall = STALL_IO;
    else if (stall_req_id) stall = STALL_ID;
    else if (stall_req_if) stall = STALL_IF;
    io_waiting = (state_q == ST_IO_WAIT);
    io_ack     = (state_q == ST_IO_ACK) && !rst;
    flush      = branch_flag && !stall[1];
  end

`ifdef STALL_PERF_EN
  logic [31:0] perf_stall_cycles_q, perf_stall_cycles_d;
  logic [15:0] perf_io_waits_q, perf_io_waits_d;

  always_comb begin
    perf_stall_cycles_d = perf_stall_cycles_q + 32'(stall[0]);
    perf_io_waits_d     = perf_io_waits_q;
    if ((state_q == ST_IO_WAIT) && (state_d == ST_IO_ACK))
      perf_io_waits_d = perf_io_waits_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cycles_q <= '0;
      perf_io_waits_q     <= '0;
    end else begin
      perf_stall_cycles_q <= perf_stall_cycles_d;
      perf_io_waits_q     <= perf_io_waits_d;
    end
  end

  assign perf_stall_cycles = perf_stall_cycles_q;
  assign perf_io_waits     = perf_io_waits_q;
`endif

endmodule
